// File: rtl/full_hk_rclk.sv
// Read-clock-domain half of a four-phase full-handshake CDC pair: synchronizes wr_vld,
// captures wr_data once per handshake, returns rd_ack, and buffers words in a valid/ready FIFO.
module full_hk_rclk #(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [DW-1:0]    wr_data,
  output logic             rd_ack,
  output logic             out_vld,
  output logic [DW-1:0]    out_data,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             fifo_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   vld_s;
  logic [DW-1:0]          mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   push;
  logic                   pop;

  assign vld_s = sync_q[SYNC_STAGES-1];

  // Full is judged on the registered count, so a pop never frees space for a capture
  // in the same cycle; the blocked request is taken on the following edge.
  assign push      = (state == IDLE) && vld_s && (count != CW'(DEPTH));
  assign pop       = out_vld && out_rdy;
  assign out_vld   = (count != '0);
  assign fifo_full = (count == CW'(DEPTH));
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    // NOTE: the storage is cleared on reset as well, because out_data is required to read
    // zero after reset; this is affordable only because the FIFO is a handful of flops.
    if (rst) begin
      sync_q   <= '0;
      state    <= IDLE;
      rd_ack   <= 1'b0;
      xfer_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every flop samples the
      // pre-edge value of the others and the synchronizer chain shifts one stage per edge.
      sync_q <= {sync_q[SYNC_STAGES-2:0], wr_vld};

      case (state)
        IDLE: begin
          if (push) begin
            state    <= ACK;
            rd_ack   <= 1'b1;
            xfer_cnt <= xfer_cnt + CNT_W'(1);
          end
        end
        ACK: begin
          if (!vld_s) begin
            state  <= IDLE;
            rd_ack <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          rd_ack <= 1'b0;
        end
      endcase

      // wr_data is stable by protocol whenever push is asserted.
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_full_hk_rclk.sv
// Directed bench for full_hk_rclk (DW=8, SYNC_STAGES=2, DEPTH=2): reset, latency,
// back-pressure with same-edge pop, held request and reset during ACK.
module tb_full_hk_rclk;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_vld;
  logic [7:0]  wr_data;
  logic        rd_ack;
  logic        out_vld;
  logic [7:0]  out_data;
  logic        out_rdy;
  logic [15:0] xfer_cnt;
  logic        fifo_full;

  int total  = 0;
  int passed = 0;

  full_hk_rclk #(
    .DW(8), .SYNC_STAGES(2), .DEPTH(2), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_vld    (wr_vld),
    .wr_data   (wr_data),
    .rd_ack    (rd_ack),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .xfer_cnt  (xfer_cnt),
    .fifo_full (fifo_full)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances until rd_ack reaches val or the budget runs out; n is the number of edges taken.
  task automatic wait_ack(input logic val, input int max_edges, input string tag, output int n);
    n = 0;
    while (rd_ack !== val && n < max_edges) begin
      tick();
      n++;
    end
    check(tag, {31'd0, rd_ack}, {31'd0, val});
  endtask

  task automatic handshake(input logic [7:0] d, input string tag);
    int n;
    wr_data = d;
    wr_vld  = 1'b1;
    wait_ack(1'b1, 10, {tag, "_ack_hi"}, n);
    wr_vld = 1'b0;
    wait_ack(1'b0, 10, {tag, "_ack_lo"}, n);
  endtask

  initial begin
    int n;
    int hi_cycles;
    logic [15:0] exp_cnt;

    rst     = 1'b1;
    wr_vld  = 1'b1;
    wr_data = 8'h5A;
    out_rdy = 1'b0;

    // Reset held for 3 edges with a request pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd_ack", {31'd0, rd_ack}, 32'd0);
      check("rst_out_vld", {31'd0, out_vld}, 32'd0);
      check("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
      check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    end
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_e1_ack", {31'd0, rd_ack}, 32'd0);
    tick();
    check("post_rst_e2_ack", {31'd0, rd_ack}, 32'd0);
    tick();
    check("post_rst_e3_ack", {31'd0, rd_ack}, 32'd1);
    check("post_rst_data", {24'd0, out_data}, 32'h5A);
    check("post_rst_cnt", {16'd0, xfer_cnt}, 32'd1);
    exp_cnt = 16'd1;
    // Drain and release.
    out_rdy = 1'b1;
    wr_vld  = 1'b0;
    tick();
    check("post_rst_drained", {31'd0, out_vld}, 32'd0);
    wait_ack(1'b0, 10, "post_rst_ack_lo", n);

    // Single transfer: 3-edge latency both ways.
    wr_data = 8'hA5;
    wr_vld  = 1'b1;
    wait_ack(1'b1, 10, "single_ack_hi", n);
    check("single_rise_latency", n, 32'd3);
    check("single_out_vld", {31'd0, out_vld}, 32'd1);
    check("single_out_data", {24'd0, out_data}, 32'hA5);
    exp_cnt = exp_cnt + 16'd1;
    check("single_cnt", {16'd0, xfer_cnt}, {16'd0, exp_cnt});
    wr_vld = 1'b0;
    wait_ack(1'b0, 10, "single_ack_lo", n);
    check("single_fall_latency", n, 32'd3);
    check("single_popped", {31'd0, out_vld}, 32'd0);

    // Back-pressure: consumer stalled, two words fill the FIFO.
    out_rdy = 1'b0;
    handshake(8'h01, "bp1");
    handshake(8'h02, "bp2");
    exp_cnt = exp_cnt + 16'd2;
    check("bp_full", {31'd0, fifo_full}, 32'd1);
    check("bp_head", {24'd0, out_data}, 32'h01);
    check("bp_cnt", {16'd0, xfer_cnt}, {16'd0, exp_cnt});
    wr_data = 8'h03;
    wr_vld  = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("bp_third_blocked", {31'd0, rd_ack}, 32'd0);
    check("bp_cnt_held", {16'd0, xfer_cnt}, {16'd0, exp_cnt});
    // One-cycle pop while full: no capture on the pop edge, capture on the next.
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("pop_edge_no_ack", {31'd0, rd_ack}, 32'd0);
    check("pop_edge_not_full", {31'd0, fifo_full}, 32'd0);
    check("pop_edge_head", {24'd0, out_data}, 32'h02);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("next_edge_ack", {31'd0, rd_ack}, 32'd1);
    check("next_edge_full", {31'd0, fifo_full}, 32'd1);
    check("next_edge_head", {24'd0, out_data}, 32'h02);
    check("next_edge_cnt", {16'd0, xfer_cnt}, {16'd0, exp_cnt});
    wr_vld = 1'b0;
    wait_ack(1'b0, 10, "bp3_ack_lo", n);
    out_rdy = 1'b1;
    tick();
    check("drain_head3", {24'd0, out_data}, 32'h03);
    tick();
    check("drain_empty", {31'd0, out_vld}, 32'd0);

    // Held request: 20 cycles of wr_vld, exactly one capture.
    wr_data   = 8'h77;
    wr_vld    = 1'b1;
    hi_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_ack === 1'b1) hi_cycles++;
    end
    exp_cnt = exp_cnt + 16'd1;
    check("held_ack_cycles", hi_cycles, 32'd18);
    check("held_single_capture", {16'd0, xfer_cnt}, {16'd0, exp_cnt});
    check("held_ack_still_hi", {31'd0, rd_ack}, 32'd1);
    wr_vld = 1'b0;
    wait_ack(1'b0, 10, "held_ack_lo", n);
    check("held_drained", {31'd0, out_vld}, 32'd0);

    // Reset during ACK with one entry, request kept high across reset.
    out_rdy = 1'b0;
    wr_data = 8'hC3;
    wr_vld  = 1'b1;
    wait_ack(1'b1, 10, "mid_ack_hi", n);
    check("mid_one_entry", {31'd0, out_vld}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ack", {31'd0, rd_ack}, 32'd0);
    check("mid_rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("mid_rst_cnt", {16'd0, xfer_cnt}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    wait_ack(1'b1, 10, "recapture_ack", n);
    check("recapture_latency", n, 32'd3);
    check("recapture_data", {24'd0, out_data}, 32'hC3);
    check("recapture_cnt", {16'd0, xfer_cnt}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
